// File: rtl/conv_output_packer.sv
`default_nettype none
// ============================================================================
// Module   : conv_output_packer
// Brief    : Bias-add, round/shift requantisation, optional ReLU and saturation
//            of convolution accumulator beats, buffered in a small output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module conv_output_packer #(
    parameter int PP_PAR     = 8,
    parameter int OC_PAR     = 16,
    parameter int ACC_WIDTH  = 28,
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic signed [PP_PAR-1:0][OC_PAR-1:0][ACC_WIDTH-1:0] acc_data,
    input  logic                                                acc_valid,
    input  logic signed [OC_PAR-1:0][ACC_WIDTH-1:0]             bias,
    input  logic [4:0]                                          shift,
    input  logic                                                relu_en,
    output logic signed [PP_PAR-1:0][OC_PAR-1:0][OUT_WIDTH-1:0] out_data,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic                                                almost_full,
    output logic                                                overflow_err,
    output logic [$clog2(FIFO_DEPTH):0]                         fifo_level
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_DW = PP_PAR * OC_PAR * OUT_WIDTH;
    localparam int c_SW = ACC_WIDTH + 1;
    // Wide enough for the biased sum plus a rounding term of up to 2^30.
    localparam int c_RW = (ACC_WIDTH + 2 > 33) ? ACC_WIDTH + 2 : 33;
    localparam logic [c_PW:0] c_FULL = (c_PW + 1)'(FIFO_DEPTH);
    localparam logic [c_PW:0] c_AF   = (c_PW + 1)'(FIFO_DEPTH - 2);

    function automatic logic [OUT_WIDTH-1:0] requant(
        input logic signed [c_SW-1:0] sum,
        input logic [4:0]             sh,
        input logic                   relu
    );
        logic signed [c_RW-1:0] v;
        logic signed [c_RW-1:0] rnd;
        logic signed [c_RW-1:0] sat_max;
        logic signed [c_RW-1:0] sat_min;
        v   = {{(c_RW - c_SW){sum[c_SW-1]}}, sum};
        rnd = '0;
        if (sh != 5'd0) rnd = c_RW'(1) << (sh - 5'd1);
        v = (v + rnd) >>> sh;
        if (relu && v[c_RW-1]) v = '0;
        sat_max = {{(c_RW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
        sat_min = ~sat_max;
        if (v > sat_max)      v = sat_max;
        else if (v < sat_min) v = sat_min;
        return v[OUT_WIDTH-1:0];
    endfunction

    logic [PP_PAR-1:0][OC_PAR-1:0][c_SW-1:0]      w_s1_sum;
    logic [PP_PAR-1:0][OC_PAR-1:0][c_SW-1:0]      r_s1_sum;
    logic [4:0]                                   r_s1_shift;
    logic                                         r_s1_relu;
    logic                                         r_s1_valid;
    logic [PP_PAR-1:0][OC_PAR-1:0][OUT_WIDTH-1:0] w_s2_data;
    logic [PP_PAR-1:0][OC_PAR-1:0][OUT_WIDTH-1:0] r_s2_data;
    logic                                         r_s2_valid;
    logic [c_DW-1:0]                              r_mem [FIFO_DEPTH];
    logic [c_PW:0]                                r_wr_ptr;
    logic [c_PW:0]                                r_rd_ptr;
    logic [c_PW:0]                                w_level;
    logic                                         w_full;
    logic                                         w_pop;
    logic                                         w_wr_en;
    logic                                         w_drop;

    always_comb begin
        w_s1_sum = '0;
        w_s2_data = '0;
        for (int p = 0; p < PP_PAR; p++) begin
            for (int c = 0; c < OC_PAR; c++) begin
                w_s1_sum[p][c]  = {acc_data[p][c][ACC_WIDTH-1], acc_data[p][c]}
                                + {bias[c][ACC_WIDTH-1], bias[c]};
                w_s2_data[p][c] = requant(r_s1_sum[p][c], r_s1_shift, r_s1_relu);
            end
        end
    end

    // Datapath and storage carry no reset; only the valids and pointers do.
    always_ff @(posedge clk) begin
        if (acc_valid) begin
            r_s1_sum   <= w_s1_sum;
            r_s1_shift <= shift;
            r_s1_relu  <= relu_en;
        end
        if (r_s1_valid) r_s2_data <= w_s2_data;
        if (w_wr_en) r_mem[r_wr_ptr[c_PW-1:0]] <= r_s2_data;
    end

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == c_FULL);
    assign w_pop   = out_valid && out_ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign w_wr_en = r_s2_valid && (!w_full || w_pop);
    assign w_drop  = r_s2_valid && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            overflow_err <= 1'b0;
        end else begin
            r_s1_valid <= acc_valid;
            r_s2_valid <= r_s1_valid;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop)  overflow_err <= 1'b1;
        end
    end

    assign out_valid   = (w_level != '0);
    assign out_data    = out_valid ? r_mem[r_rd_ptr[c_PW-1:0]] : '0;
    assign fifo_level  = w_level;
    assign almost_full = (w_level >= c_AF);

endmodule
`default_nettype wire

// File: tb/tb_conv_output_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_output_packer
// Brief    : Self-checking bench for conv_output_packer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_output_packer;

    localparam int PP    = 2;
    localparam int OC    = 4;
    localparam int AW    = 28;
    localparam int OW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef logic [PP-1:0][OC-1:0][OW-1:0] beat_t;

    logic                                clk = 1'b0;
    logic                                rst;
    logic signed [PP-1:0][OC-1:0][AW-1:0] acc_data;
    logic                                acc_valid;
    logic signed [OC-1:0][AW-1:0]        bias;
    logic [4:0]                          shift;
    logic                                relu_en;
    logic signed [PP-1:0][OC-1:0][OW-1:0] out_data;
    logic                                out_valid;
    logic                                out_ready;
    logic                                almost_full;
    logic                                overflow_err;
    logic [LW-1:0]                       fifo_level;

    int    n_vec  = 0;
    int    n_miss = 0;
    beat_t mq[$];
    beat_t pipe_d[2];
    bit    pipe_v[2];
    bit    m_ovf;

    always #5 clk = ~clk;

    conv_output_packer #(
        .PP_PAR(PP), .OC_PAR(OC), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .acc_data(acc_data), .acc_valid(acc_valid),
        .bias(bias), .shift(shift), .relu_en(relu_en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .almost_full(almost_full),
        .overflow_err(overflow_err), .fifo_level(fifo_level)
    );

    function automatic beat_t model(input logic signed [PP-1:0][OC-1:0][AW-1:0] a,
                                    input logic signed [OC-1:0][AW-1:0] b,
                                    input int sh, input bit relu);
        beat_t  r;
        longint v, av, bv, hi, lo;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -hi - 1;
        for (int p = 0; p < PP; p++) begin
            for (int c = 0; c < OC; c++) begin
                av = $signed(a[p][c]);
                bv = $signed(b[c]);
                v  = av + bv;
                if (sh > 0) v = v + (longint'(1) << (sh - 1));
                v = v >>> sh;
                if (relu && v < 0) v = 0;
                if (v > hi) v = hi;
                if (v < lo) v = lo;
                r[p][c] = v[OW-1:0];
            end
        end
        return r;
    endfunction

    function automatic beat_t fill(input int val);
        beat_t r;
        for (int p = 0; p < PP; p++)
            for (int c = 0; c < OC; c++) r[p][c] = OW'(val);
        return r;
    endfunction

    task automatic set_acc_all(input int val);
        for (int p = 0; p < PP; p++)
            for (int c = 0; c < OC; c++) acc_data[p][c] = AW'(val);
    endtask

    task automatic set_bias_all(input int val);
        for (int c = 0; c < OC; c++) bias[c] = AW'(val);
    endtask

    task automatic model_reset();
        mq.delete();
        pipe_v[0] = 1'b0;
        pipe_v[1] = 1'b0;
        m_ovf     = 1'b0;
    endtask

    // Advance the model by one clock using the inputs as they stand, then the DUT.
    task automatic tick();
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (pipe_v[1]) begin
            if (mq.size() < DEPTH) mq.push_back(pipe_d[1]);
            else                   m_ovf = 1'b1;
        end
        pipe_v[1] = pipe_v[0];
        pipe_d[1] = pipe_d[0];
        pipe_v[0] = acc_valid;
        pipe_d[0] = model(acc_data, bias, int'(shift), relu_en);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        acc_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; acc_valid = 1'b0; out_ready = 1'b1;
        set_acc_all(0); set_bias_all(0); shift = 5'd0; relu_en = 1'b0;
        model_reset();
        #2;
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (fifo_level !== '0) begin n_miss++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        n_vec++; if (almost_full !== 1'b0) begin n_miss++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
        n_vec++; if (overflow_err !== 1'b0) begin n_miss++; $display("FAIL reset_overflow got %b want 0", overflow_err); end
        n_vec++; if (out_data !== '0) begin n_miss++; $display("FAIL reset_out_data got %h want 0", out_data); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        set_bias_all(24); shift = 5'd4; relu_en = 1'b0; set_acc_all(1000);
        acc_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            logic exp_v;
            tick();
            acc_valid = 1'b0;
            exp_v = (k == 3);
            n_vec++; if (out_valid !== exp_v) begin n_miss++; $display("FAIL basic_latency cycle %0d got %b want %b", k, out_valid, exp_v); end
        end
        n_vec++; if (out_data !== fill(64)) begin n_miss++; $display("FAIL basic_value got %h want %h", out_data, fill(64)); end
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL basic_pop got %b want 0", out_valid); end
    endtask

    // Two beats back to back through a ready sink; the second differs in one quasi-static input.
    task automatic test_pair(input string name, input int a0, input int a1, input int b,
                             input int sh, input bit r0, input bit r1, input int e0, input int e1);
        do_reset();
        out_ready = 1'b1; set_bias_all(b); shift = 5'(sh);
        for (int t = 1; t <= 4; t++) begin
            acc_valid = (t <= 2);
            set_acc_all((t == 1) ? a0 : a1);
            relu_en = (t == 1) ? r0 : r1;
            tick();
            if (t >= 3) begin
                beat_t e;
                e = fill((t == 3) ? e0 : e1);
                n_vec++; if (out_valid !== 1'b1 || out_data !== e) begin n_miss++; $display("FAIL %s beat %0d got v=%b %h want %h", name, t - 2, out_valid, out_data, e); end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        set_bias_all(0); shift = 5'd0; relu_en = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            acc_valid = (t <= 5);
            set_acc_all(t);
            tick();
            if (t == 3) begin
                n_vec++; if (almost_full !== 1'b0) begin n_miss++; $display("FAIL ovf_af_one got %b want 0", almost_full); end
            end
            if (t == 4) begin
                n_vec++; if (fifo_level !== LW'(2) || almost_full !== 1'b1) begin n_miss++; $display("FAIL ovf_af_two got lvl=%0d af=%b want 2 1", fifo_level, almost_full); end
            end
            if (t == 6) begin
                n_vec++; if (overflow_err !== 1'b0) begin n_miss++; $display("FAIL ovf_early got %b want 0", overflow_err); end
            end
        end
        n_vec++; if (fifo_level !== LW'(4) || overflow_err !== 1'b1) begin n_miss++; $display("FAIL ovf_full got lvl=%0d ovf=%b want 4 1", fifo_level, overflow_err); end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_vec++; if (out_valid !== 1'b1 || out_data !== fill(k)) begin n_miss++; $display("FAIL ovf_drain %0d got v=%b %h want %h", k, out_valid, out_data, fill(k)); end
            tick();
        end
        n_vec++; if (out_valid !== 1'b0 || overflow_err !== 1'b1) begin n_miss++; $display("FAIL ovf_after got v=%b ovf=%b want 0 1", out_valid, overflow_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_bias_all(0); shift = 5'd0; relu_en = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            acc_valid = (t <= 12);
            out_ready = (t >= 7);
            set_acc_all(t);
            tick();
            if (t >= 6 && t <= 14) begin
                n_vec++; if (fifo_level !== LW'(4)) begin n_miss++; $display("FAIL b2b_level t=%0d got %0d want 4", t, fifo_level); end
            end
            if (t >= 6 && t <= 17) begin
                n_vec++; if (out_valid !== 1'b1 || out_data !== fill(t - 5)) begin n_miss++; $display("FAIL b2b_order t=%0d got v=%b %h want %h", t, out_valid, out_data, fill(t - 5)); end
            end
        end
        n_vec++; if (out_valid !== 1'b0 || overflow_err !== 1'b0) begin n_miss++; $display("FAIL b2b_end got v=%b ovf=%b want 0 0", out_valid, overflow_err); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_bias_all(0); shift = 5'd0; relu_en = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            acc_valid = 1'b1;
            set_acc_all(t + 40);
            tick();
        end
        acc_valid = 1'b0;
        n_vec++; if (fifo_level !== LW'(3)) begin n_miss++; $display("FAIL midrst_pre got %0d want 3", fifo_level); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++; if (out_valid !== 1'b0 || fifo_level !== '0) begin n_miss++; $display("FAIL midrst_async got v=%b lvl=%0d want 0 0", out_valid, fifo_level); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL midrst_stale cycle %0d got %b want 0", k, out_valid); end
        end
        out_ready = 1'b0;
        acc_valid = 1'b1;
        set_acc_all(77);
        tick();
        acc_valid = 1'b0;
        tick();
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_data !== fill(77) || fifo_level !== LW'(1)) begin n_miss++; $display("FAIL midrst_new got v=%b %h lvl=%0d want 1 %h 1", out_valid, out_data, fifo_level, fill(77)); end
    endtask

    task automatic test_random();
        do_reset();
        set_bias_all(0); shift = 5'd0; relu_en = 1'b0;
        for (int n = 0; n < 400; n++) begin
            beat_t    e;
            logic [LW-1:0] el;
            acc_valid = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            for (int p = 0; p < PP; p++) begin
                for (int c = 0; c < OC; c++) begin
                    case ($urandom_range(0, 2))
                        0:       acc_data[p][c] = AW'(longint'($urandom_range(0, 4095)) - 2048);
                        1:       acc_data[p][c] = AW'($urandom());
                        default: acc_data[p][c] = AW'(longint'($urandom_range(0, 400000)) - 200000);
                    endcase
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                for (int c = 0; c < OC; c++) bias[c] = AW'(longint'($urandom_range(0, 2000000)) - 1000000);
                shift   = 5'($urandom_range(0, 31));
                relu_en = 1'($urandom_range(0, 1));
            end
            tick();
            el = LW'(mq.size());
            e  = (mq.size() > 0) ? mq[0] : '0;
            n_vec++; if (out_valid !== (mq.size() > 0)) begin n_miss++; $display("FAIL rnd_valid n=%0d got %b want %b", n, out_valid, mq.size() > 0); end
            n_vec++; if (fifo_level !== el) begin n_miss++; $display("FAIL rnd_level n=%0d got %0d want %0d", n, fifo_level, el); end
            n_vec++; if (out_data !== e) begin n_miss++; $display("FAIL rnd_data n=%0d got %h want %h", n, out_data, e); end
            n_vec++; if (almost_full !== (mq.size() >= DEPTH - 2)) begin n_miss++; $display("FAIL rnd_af n=%0d got %b want %b", n, almost_full, mq.size() >= DEPTH - 2); end
            n_vec++; if (overflow_err !== m_ovf) begin n_miss++; $display("FAIL rnd_ovf n=%0d got %b want %b", n, overflow_err, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pair("relu", -24, -24, 0, 4, 1'b0, 1'b1, -1, 0);
        test_pair("saturate", 100000, -100000, 0, 0, 1'b0, 1'b0, 127, -128);
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_output_packer.md
CONV_OUTPUT_PACKER -- requirements
Module: conv_output_packer

Interface
REQ-001 SHALL have parameter PP_PAR, default 8, meaning pixels per beat.
REQ-002 SHALL have parameter OC_PAR, default 16, meaning output channels per beat.
REQ-003 SHALL have parameter ACC_WIDTH, default 28, meaning signed accumulator width.
REQ-004 SHALL have parameter OUT_WIDTH, default 8, meaning signed output width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries; it shall be a power of 2 and at least 4.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port acc_data  input  signed [PP_PAR][OC_PAR][ACC_WIDTH]  accumulator beat from the convolution engine.
REQ-009 SHALL have port acc_valid  input  1  beat valid; no backpressure exists on this side.
REQ-010 SHALL have port bias  input  signed [OC_PAR][ACC_WIDTH]  per-channel bias, quasi-static.
REQ-011 SHALL have port shift  input  5  requantization right shift, 0..31, quasi-static.
REQ-012 SHALL have port relu_en  input  1  clamp negatives to 0 when 1, quasi-static.
REQ-013 SHALL have port out_data  output  signed [PP_PAR][OC_PAR][OUT_WIDTH]  FIFO head.
REQ-014 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-015 SHALL have port out_ready  input  1  downstream accept.
REQ-016 SHALL have port almost_full  output  1  upstream stall hint.
REQ-017 SHALL have port overflow_err  output  1  sticky, set when a result is dropped.
REQ-018 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-019 SHALL use a 2-stage pipeline: S1 registers acc_data[p][c] + bias[c] at ACC_WIDTH+1 bits, together with the valid bit.
REQ-020 SHALL, in S2, add rounding constant 1<<(shift-1) when shift>0, arithmetic-right-shift by shift, apply ReLU if relu_en, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-021 SHALL size all intermediates so that no wrap occurs before saturation.
REQ-022 SHALL push the S2 result into the FIFO exactly 2 cycles after acc_valid is sampled high; latency acc_valid to out_valid is 3 cycles when the FIFO is empty.
REQ-023 SHALL assert out_valid iff fifo_level>0; out_data shall be the FIFO head; out_data shall hold stable while out_valid=1 and out_ready=0.
REQ-024 SHALL pop the FIFO on out_valid && out_ready, and shall ignore out_ready when the FIFO is empty.
REQ-025 SHALL deliver results in strict arrival order.
REQ-026 SHALL, on simultaneous push and pop, leave fifo_level unchanged; this includes the full case, where no drop occurs.
REQ-027 SHALL, on a push while full without a pop, drop the result, keep the FIFO contents intact, and set overflow_err; overflow_err shall stay high until reset.
REQ-028 SHALL assert almost_full combinationally when fifo_level >= FIFO_DEPTH-2, covering the 2 beats in flight.
REQ-029 SHALL capture bias, shift and relu_en in S1/S2 on the same cycle as the data; changes while data is in flight are the user's responsibility and shall not be flagged.
REQ-030 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH using an extra wrap bit for the full/empty distinction.

Reset
REQ-031 SHALL, while rst=1 (asynchronous), clear pipeline valids, FIFO pointers and overflow_err, and drive out_valid=0, fifo_level=0, almost_full=0 and out_data=0.
REQ-032 SHALL discard beats in flight on reset mid-operation; the first output after rst falls shall come from a beat sampled after the release.

Verification
REQ-033 SHALL be verified by: acc=1000, bias=24, shift=4, relu_en=0 -> out 64 (1032>>4), out_valid 3 cycles after acc_valid.
REQ-034 SHALL be verified by: acc=-24, bias=0, shift=4 -> -1; same beat with relu_en=1 -> 0.
REQ-035 SHALL be verified by: acc=100000 and acc=-100000, shift=0 -> 127 and -128 respectively.
REQ-036 SHALL be verified by: out_ready=0, 5 back-to-back beats with values 1..5 -> fifo_level=4, almost_full=1 after the second push, overflow_err=1, and the drain yields 1,2,3,4.
REQ-037 SHALL be verified by: FIFO full with out_ready=1 and continuous acc_valid -> level stays 4, no overflow, all values delivered in order.
REQ-038 SHALL be verified by: rst pulsed with 2 beats in flight and 3 in the FIFO -> out_valid=0 and level=0 immediately, with no stale output afterwards.
